// File: rtl/voice_mixer.sv
// voice_mixer: per-sample wavetable mixer, one ROM read per voice slot, summed into one signed sample.
// Latency tick->sample_valid_out is n+RAM_LATENCY+1 cycles; ticks arriving while busy are dropped and flagged.
// Optional VOICE_MIXER_NORMALIZE_EN: scale the output by active voice count with saturation.
module voice_mixer #(
   parameter int ADDR_WIDTH   = 8,
   parameter int NUM_NOTES    = 24,
   parameter int NUM_VOICES   = 8,
   parameter int SAMPLE_WIDTH = 8,
   parameter int OUT_WIDTH    = 16,
   parameter int RAM_LATENCY  = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic                           sample_tick_in,
   input  logic [ADDR_WIDTH*NUM_NOTES-1:0] addr_in,
   input  logic [3:0]                     num_voices_in,
   input  logic [5*NUM_VOICES-1:0]        active_voices_idx_in,
   output logic [ADDR_WIDTH+1:0]          rom_addr_out,
   output logic                           rom_en_out,
   input  logic [SAMPLE_WIDTH-1:0]        rom_data_in,
   output logic [OUT_WIDTH-1:0]           sample_out,
   output logic                           sample_valid_out,
   output logic                           busy_out,
   output logic                           overrun_out
);

   localparam int ACC_W = SAMPLE_WIDTH + 3;
   localparam int DW    = $clog2(RAM_LATENCY + 1);
   localparam int SHIFT = OUT_WIDTH - SAMPLE_WIDTH - 3;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUTPUT} state_t;

   state_t                        state_q, state_d;
   logic [3:0]                    n_q, n_clamp;
   logic [2:0]                    slot_q;
   logic [DW-1:0]                 drain_q;
   logic [RAM_LATENCY-1:0]        ret_q;
   logic signed [ACC_W-1:0]       acc_q, acc_nxt;
   logic signed [SAMPLE_WIDTH-1:0] ret_s;
   logic signed [OUT_WIDTH-1:0]   mix;
   logic [4:0]                    idx_q  [8];
   logic [ADDR_WIDTH-1:0]         addr_q [8];
   logic [39:0]                   idx_pad;
   logic [32*ADDR_WIDTH-1:0]      addr_pad;
   logic                          slot_vld;

   // Zero padding: unused slots are never presented since n is clamped to NUM_VOICES.
   assign idx_pad  = 40'(active_voices_idx_in);
   assign addr_pad = (32*ADDR_WIDTH)'(addr_in);
   assign n_clamp  = (num_voices_in > 4'(NUM_VOICES)) ? 4'(NUM_VOICES) : num_voices_in;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (sample_tick_in) state_d = (n_clamp == 4'd0) ? S_DRAIN : S_ISSUE;
         S_ISSUE:  if ({1'b0, slot_q} == n_q - 4'd1) state_d = S_DRAIN;
         S_DRAIN:  if (drain_q == DW'(RAM_LATENCY - 1)) state_d = S_OUTPUT;
         S_OUTPUT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign slot_vld         = (state_q == S_ISSUE) && ({1'b0, idx_q[slot_q]} < 6'(NUM_NOTES));
   assign rom_en_out       = slot_vld;
   assign rom_addr_out     = slot_vld ? {idx_q[slot_q][4:3], addr_q[slot_q]} : '0;
   assign busy_out         = (state_q != S_IDLE);
   assign overrun_out      = sample_tick_in && (state_q != S_IDLE);
   assign sample_valid_out = (state_q == S_OUTPUT);

   // Offset-binary to two's complement is an MSB flip.
   assign ret_s = {~rom_data_in[SAMPLE_WIDTH-1], rom_data_in[SAMPLE_WIDTH-2:0]};

   always_comb begin
      acc_nxt = acc_q;
      if (ret_q[RAM_LATENCY-1]) acc_nxt = acc_q + ACC_W'(ret_s);
   end

`ifdef VOICE_MIXER_NORMALIZE_EN
   function automatic int norm_shift(input logic [3:0] n);
      if (n <= 4'd1)      return 0;
      else if (n <= 4'd2) return 1;
      else if (n <= 4'd4) return 2;
      else                return 3;
   endfunction

   logic signed [OUT_WIDTH+2:0] wide;

   always_comb begin
      wide = (OUT_WIDTH+3)'(acc_nxt) <<< (OUT_WIDTH - SAMPLE_WIDTH - norm_shift(n_q));
      if (wide[OUT_WIDTH+2:OUT_WIDTH-1] != {4{wide[OUT_WIDTH+2]}})
         mix = wide[OUT_WIDTH+2] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else
         mix = wide[OUT_WIDTH-1:0];
   end
`else
   always_comb begin
      mix = OUT_WIDTH'(acc_nxt) <<< SHIFT;
   end
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         slot_q     <= '0;
         drain_q    <= '0;
         ret_q      <= '0;
         acc_q      <= '0;
         sample_out <= '0;
         for (int v = 0; v < 8; v++) begin
            idx_q[v]  <= 5'h1F;
            addr_q[v] <= '0;
         end
      end else begin
         state_q <= state_d;
         slot_q  <= (state_q == S_ISSUE) ? slot_q + 3'd1 : 3'd0;
         drain_q <= (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
         ret_q   <= (ret_q << 1) | RAM_LATENCY'(rom_en_out);
         if (state_q == S_IDLE && sample_tick_in) begin
            n_q   <= n_clamp;
            acc_q <= '0;
            for (int v = 0; v < 8; v++) begin
               idx_q[v]  <= idx_pad[v*5 +: 5];
               addr_q[v] <= addr_pad[int'(idx_pad[v*5 +: 5])*ADDR_WIDTH +: ADDR_WIDTH];
            end
         end else begin
            acc_q <= acc_nxt;
         end
         // Capture includes the final return landing on this edge.
         if (state_q == S_DRAIN && state_d == S_OUTPUT) sample_out <= mix;
      end
   end

endmodule

// File: doc/voice_mixer.md
Name: voice_mixer

Overview:
Downstream stage of the voice allocator/address generator. Once per audio sample tick it snapshots the allocator's active-voice list and per-note wavetable addresses. It then issues one wavetable read per voice slot to a synchronous waveform ROM, sums the returned samples as signed values, and presents one scaled signed mix sample to the DAC/PWM stage.

Parameters:
ADDR_WIDTH, 8, per-waveform table address width (matches allocator addr_out).
NUM_NOTES, 24, notes; notes 0-7 use waveform 0, 8-15 waveform 1, 16-23 waveform 2.
NUM_VOICES, 8, max simultaneous voices; must be <= 8.
SAMPLE_WIDTH, 8, ROM sample width, offset-binary.
OUT_WIDTH, 16, mix output width, signed; must be >= SAMPLE_WIDTH+3.
RAM_LATENCY, 2, ROM read latency in cycles (>=1).

Ports:
clk_in  input  1  system clock.
rst_n_in  input  1  asynchronous, active-low reset.
sample_tick_in  input  1  one-cycle pulse per audio sample.
addr_in  input  ADDR_WIDTH x NUM_NOTES  per-note wavetable address.
num_voices_in  input  4  active voice count.
active_voices_idx_in  input  5 x NUM_VOICES  note index per voice slot; 5'b11111 = empty.
rom_addr_out  output  ADDR_WIDTH+2  {waveform_sel[1:0], addr}.
rom_en_out  output  1  ROM read enable.
rom_data_in  input  SAMPLE_WIDTH  ROM data, valid RAM_LATENCY cycles after the enabled address.
sample_out  output  OUT_WIDTH  signed mix sample; holds its value between updates.
sample_valid_out  output  1  one-cycle pulse when sample_out updates.
busy_out  output  1  high while not IDLE.
overrun_out  output  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs are 0: rom_addr_out, rom_en_out, sample_out, sample_valid_out, busy_out, overrun_out. The accumulator and the return-valid pipe clear. ROM returns still in flight are discarded.
- FSM IDLE -> ISSUE -> DRAIN -> OUTPUT -> IDLE.
- IDLE, tick at edge T:
  - Latch n = min(num_voices_in, NUM_VOICES), all active_voices_idx_in, and addr_in of each indexed note.
  - Clear accumulator; go to ISSUE.
  - Later changes on any input do not affect this sample.
- ISSUE: slot k (0..n-1) is presented in cycle T+1+k, one slot per cycle.
  - If idx < NUM_NOTES: rom_en_out=1 and rom_addr_out={idx/8, addr}.
  - Otherwise the slot is skipped: rom_en_out=0, contributes 0, and still consumes its cycle.
  - After slot n-1, or immediately when n=0, go to DRAIN.
- Returns are tracked by a RAM_LATENCY-deep enable shift register.
  - Each valid return adds (rom_data_in - 2^(SAMPLE_WIDTH-1)) as a signed value to the accumulator.
  - Accumulator width is SAMPLE_WIDTH+3 bits, signed. It cannot overflow for 8 voices.
- DRAIN: wait until the pipe is empty.
- OUTPUT:
  - sample_out = sign-extended accumulator << (OUT_WIDTH-SAMPLE_WIDTH-3).
  - sample_valid_out=1 for exactly one cycle; then return to IDLE.
- Latency: sample_valid_out is high in cycle T+n+RAM_LATENCY+1. This includes n=0, whose result is 0.
- busy_out is high from T+1 through the OUTPUT cycle inclusive.
- A tick arriving while busy is dropped: overrun_out pulses in that cycle and the in-progress mix is unaffected.
- A tick in the same cycle as OUTPUT is also dropped. A tick in the first IDLE cycle is accepted.
- num_voices_in > NUM_VOICES is clamped to NUM_VOICES.
- Empty or out-of-range slot indices below n are treated as skipped.

Optional Feature:
VOICE_MIXER_NORMALIZE_EN:
- Defined: the output shift is (OUT_WIDTH-SAMPLE_WIDTH-s), where s = ceil(log2(max(n,1))), so n=1 gives s=0 and n in 5..8 gives s=3.
  - Quieter mixes are boosted.
  - The result saturates to the OUT_WIDTH signed range.
- Undefined: fixed shift s=3 as above; no saturation logic.

Test Plan:
- Reset held low mid-ISSUE with n=4, then released -> all outputs 0; no sample_valid_out for the aborted mix; the next tick produces a normal mix.
- n=1, idx0=3, addr[3]=0x40, ROM returns 0xC0, tick at T -> rom_addr_out=0x040 with rom_en_out=1 at T+1; sample_out=0x0800 with sample_valid_out at T+4; busy_out high T+1..T+4.
- n=2, idx={2,10}, addr[2]=0x11, addr[10]=0x22 -> rom_addr_out=0x011 at T+1, 0x122 at T+2; ROM returns 0x90 and 0x70 -> sample_out=0x0000 at T+5.
- n=8, all indices valid, ROM returns 0x00 for every read -> sample_out=0x8000. Same with ROM returning 0xFF -> 0x7F00. Both at T+11.
- n=3, idx={4,5'b11111,6}, ROM returns 0xA0 -> rom_en_out pattern 1,0,1; sample_out=(32+32)<<5=0x0800 at T+6.
- Second tick at T+2 during a 1-voice mix -> overrun_out pulse at T+2; exactly one sample_valid_out (at T+4). A tick at T+5 is accepted. n=0 tick -> sample_out=0 at T+3.
